// File: rtl/dma_axi_to_reg_pkg.sv
// Shared types and constants for the AXI-to-register bridge.
// Optional feature macro: DMA_AXI_TO_REG_SLVERR_EN (SLVERR reporting on B/R).
package dma_axi_to_reg_pkg;

   localparam int unsigned AXI_ADDR_WIDTH = 64;
   localparam int unsigned AXI_DATA_WIDTH = 64;
   localparam int unsigned AXI_ID_WIDTH   = 4;
   localparam int unsigned AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

   // Beat counter width; matches the 8-bit AXI len field.
   localparam int unsigned BEAT_CNT_WIDTH = 8;

   // AXI response codes.
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   // AXI burst types.
   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR_DATA = 3'd1,
      WR_RESP = 3'd2,
      RD_REQ  = 3'd3,
      RD_RESP = 3'd4
   } state_e;

   typedef struct packed {
      logic [AXI_ID_WIDTH-1:0]   id;
      logic [AXI_ADDR_WIDTH-1:0] addr;
      logic [7:0]                len;
      logic [2:0]                size;
      logic [1:0]                burst;
   } axi_ax_chan_t;

   typedef struct packed {
      logic [AXI_DATA_WIDTH-1:0] data;
      logic [AXI_STRB_WIDTH-1:0] strb;
      logic                      last;
   } axi_w_chan_t;

   typedef struct packed {
      logic [AXI_ID_WIDTH-1:0] id;
      logic [1:0]              resp;
   } axi_b_chan_t;

   typedef struct packed {
      logic [AXI_ID_WIDTH-1:0]   id;
      logic [AXI_DATA_WIDTH-1:0] data;
      logic [1:0]                resp;
      logic                      last;
   } axi_r_chan_t;

   typedef struct packed {
      axi_ax_chan_t aw;
      logic         aw_valid;
      axi_w_chan_t  w;
      logic         w_valid;
      logic         b_ready;
      axi_ax_chan_t ar;
      logic         ar_valid;
      logic         r_ready;
   } dma_axi_req_t;

   typedef struct packed {
      logic        aw_ready;
      logic        ar_ready;
      logic        w_ready;
      logic        b_valid;
      axi_b_chan_t b;
      logic        r_valid;
      axi_r_chan_t r;
   } dma_axi_rsp_t;

   typedef struct packed {
      logic [AXI_ADDR_WIDTH-1:0] addr;
      logic                      write;
      logic [AXI_DATA_WIDTH-1:0] wdata;
      logic [AXI_STRB_WIDTH-1:0] wstrb;
      logic                      valid;
   } dma_reg_req_t;

   typedef struct packed {
      logic [AXI_DATA_WIDTH-1:0] rdata;
      logic                      error;
      logic                      ready;
   } dma_reg_rsp_t;

endpackage

// File: rtl/dma_axi_to_reg_addr_gen.sv
// Next-beat address for an AXI burst. FIXED holds the address; INCR (and
// WRAP, which is handled as INCR) aligns down to the beat size and steps by
// one beat, wrapping at the top of the address space.
module dma_axi_to_reg_addr_gen
   import dma_axi_to_reg_pkg::*;
#(
   parameter int unsigned AddrWidth = 64
) (
   input  logic [AddrWidth-1:0] addr,
   input  logic [2:0]           size,
   input  logic [1:0]           burst,
   output logic [AddrWidth-1:0] next_addr
);

   logic [AddrWidth-1:0] step;
   logic [AddrWidth-1:0] aligned;

   // Compute the aligned base and the stepped address.
   always_comb begin
      step    = AddrWidth'(1) << size;
      aligned = addr & ~(step - AddrWidth'(1));
      if (burst == BURST_FIXED) begin
         next_addr = addr;
      end else begin
         next_addr = aligned + step;
      end
   end

endmodule

// File: rtl/dma_axi_to_reg.sv
// AXI4 subordinate that splits each read/write burst into single-beat
// register-interface accesses, one transaction at a time.
// Optional feature macro: DMA_AXI_TO_REG_SLVERR_EN -- when defined, register
// errors are reported as SLVERR on B (any beat) and R (per beat).
//
// Handshake rule on every channel: a transfer happens on a rising clk_i edge
// where valid and ready are both 1; a producer never withdraws or changes a
// payload while its valid is 1 and ready is 0.
module dma_axi_to_reg
   import dma_axi_to_reg_pkg::*;
#(
   parameter int unsigned AxiAddrWidth = AXI_ADDR_WIDTH,
   parameter int unsigned AxiDataWidth = AXI_DATA_WIDTH,
   parameter int unsigned AxiIdWidth   = AXI_ID_WIDTH,
   parameter type axi_req_t = dma_axi_req_t,
   parameter type axi_rsp_t = dma_axi_rsp_t,
   parameter type reg_req_t = dma_reg_req_t,
   parameter type reg_rsp_t = dma_reg_rsp_t
) (
   input  logic     clk_i,
   input  logic     rst_i,
   input  axi_req_t axi_req_i,
   output axi_rsp_t axi_rsp_o,
   output reg_req_t reg_req_o,
   input  reg_rsp_t reg_rsp_i
);

   localparam logic [2:0] MaxSize = 3'($clog2(AxiDataWidth / 8));

   state_e                    state_q, state_d;
   logic [AxiIdWidth-1:0]     id_q;
   logic [AxiAddrWidth-1:0]   addr_q;
   logic [AxiAddrWidth-1:0]   next_addr;
   logic [7:0]                len_q;
   logic [2:0]                size_q;
   logic [1:0]                burst_q;
   logic [BEAT_CNT_WIDTH-1:0] cnt_q;
   logic                      last_write_q;
   logic [AxiDataWidth-1:0]   rdata_q;

   logic aw_grant, ar_grant, advance, w_hs, b_hs, rd_capture, last_beat;
   logic [1:0] resp_b, resp_r;

   assign last_beat = (cnt_q == len_q);

   dma_axi_to_reg_addr_gen #(
      .AddrWidth(AxiAddrWidth)
   ) u_addr_gen (
      .addr     (addr_q),
      .size     (size_q),
      .burst    (burst_q),
      .next_addr(next_addr)
   );

`ifdef DMA_AXI_TO_REG_SLVERR_EN
   logic err_q;
   logic rerr_q;

   // Accumulate write-burst errors until B is taken; keep per-beat read error.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         err_q  <= 1'b0;
         rerr_q <= 1'b0;
      end else begin
         if (w_hs && reg_rsp_i.error) begin
            err_q <= 1'b1;
         end else if (b_hs) begin
            err_q <= 1'b0;
         end
         if (rd_capture) begin
            rerr_q <= reg_rsp_i.error;
         end
      end
   end

   assign resp_b = err_q  ? RESP_SLVERR : RESP_OKAY;
   assign resp_r = rerr_q ? RESP_SLVERR : RESP_OKAY;
`else
   assign resp_b = RESP_OKAY;
   assign resp_r = RESP_OKAY;
`endif

   // State register, latched burst descriptor, beat counter and read buffer.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         id_q         <= '0;
         addr_q       <= '0;
         len_q        <= '0;
         size_q       <= '0;
         burst_q      <= '0;
         cnt_q        <= '0;
         last_write_q <= 1'b0;
         rdata_q      <= '0;
      end else begin
         state_q <= state_d;
         if (aw_grant) begin
            id_q         <= axi_req_i.aw.id;
            addr_q       <= axi_req_i.aw.addr;
            len_q        <= axi_req_i.aw.len;
            size_q       <= axi_req_i.aw.size;
            burst_q      <= axi_req_i.aw.burst;
            cnt_q        <= '0;
            last_write_q <= 1'b1;
         end else if (ar_grant) begin
            id_q         <= axi_req_i.ar.id;
            addr_q       <= axi_req_i.ar.addr;
            len_q        <= axi_req_i.ar.len;
            size_q       <= axi_req_i.ar.size;
            burst_q      <= axi_req_i.ar.burst;
            cnt_q        <= '0;
            last_write_q <= 1'b0;
         end else if (advance) begin
            addr_q <= next_addr;
            cnt_q  <= cnt_q + BEAT_CNT_WIDTH'(1);
         end
         if (rd_capture) begin
            rdata_q <= reg_rsp_i.rdata;
         end
      end
   end

   // Next state and all channel outputs, decoded from the current state.
   always_comb begin
      state_d    = state_q;
      axi_rsp_o  = '0;
      reg_req_o  = '0;
      aw_grant   = 1'b0;
      ar_grant   = 1'b0;
      advance    = 1'b0;
      w_hs       = 1'b0;
      b_hs       = 1'b0;
      rd_capture = 1'b0;
      reg_req_o.addr = addr_q;
      case (state_q)
         IDLE: begin
            // Round-robin on a tie: write wins unless the last grant was a write.
            if (axi_req_i.aw_valid && (!axi_req_i.ar_valid || !last_write_q)) begin
               axi_rsp_o.aw_ready = 1'b1;
               aw_grant           = 1'b1;
               state_d            = WR_DATA;
            end else if (axi_req_i.ar_valid) begin
               axi_rsp_o.ar_ready = 1'b1;
               ar_grant           = 1'b1;
               state_d            = RD_REQ;
            end
         end
         WR_DATA: begin
            reg_req_o.valid    = axi_req_i.w_valid;
            reg_req_o.write    = 1'b1;
            reg_req_o.wdata    = axi_req_i.w.data;
            reg_req_o.wstrb    = axi_req_i.w.strb;
            axi_rsp_o.w_ready  = reg_rsp_i.ready;
            w_hs               = axi_req_i.w_valid && reg_rsp_i.ready;
            if (w_hs) begin
               if (last_beat) begin
                  state_d = WR_RESP;
               end else begin
                  advance = 1'b1;
               end
            end
         end
         WR_RESP: begin
            axi_rsp_o.b_valid = 1'b1;
            axi_rsp_o.b.id    = id_q;
            axi_rsp_o.b.resp  = resp_b;
            if (axi_req_i.b_ready) begin
               b_hs    = 1'b1;
               state_d = IDLE;
            end
         end
         RD_REQ: begin
            reg_req_o.valid = 1'b1;
            if (reg_rsp_i.ready) begin
               rd_capture = 1'b1;
               state_d    = RD_RESP;
            end
         end
         RD_RESP: begin
            axi_rsp_o.r_valid = 1'b1;
            axi_rsp_o.r.id    = id_q;
            axi_rsp_o.r.data  = rdata_q;
            axi_rsp_o.r.resp  = resp_r;
            axi_rsp_o.r.last  = last_beat;
            if (axi_req_i.r_ready) begin
               if (last_beat) begin
                  state_d = IDLE;
               end else begin
                  advance = 1'b1;
                  state_d = RD_REQ;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // W.last must agree with the len-derived beat count.
   a_w_last: assert property (@(posedge clk_i) disable iff (rst_i)
      w_hs |-> (axi_req_i.w.last == last_beat));

   // Beat size may not exceed the data bus width.
   a_aw_size: assert property (@(posedge clk_i) disable iff (rst_i)
      aw_grant |-> (axi_req_i.aw.size <= MaxSize));
   a_ar_size: assert property (@(posedge clk_i) disable iff (rst_i)
      ar_grant |-> (axi_req_i.ar.size <= MaxSize));

   // WRAP bursts are walked as INCR; flag their use.
   a_aw_wrap: assert property (@(posedge clk_i) disable iff (rst_i)
      aw_grant |-> (axi_req_i.aw.burst != BURST_WRAP));
   a_ar_wrap: assert property (@(posedge clk_i) disable iff (rst_i)
      ar_grant |-> (axi_req_i.ar.burst != BURST_WRAP));

endmodule
